switch_launcher: RTL and testbench

Board-level launcher that turns raw switch inputs into start/busy transactions for a single compute kernel and latches the kernel's result onto the board outputs. It sits between the FPGA switch/LED pins and any kernel that has a one-cycle `start` strobe, a `busy` flag and a result bus. It adds input synchronisation and debouncing, a configurable argument range check, a continuous re-run mode, a busy timeout and a latched result with status flags.

---
 rtl/switch_launcher.sv | 172 +++++++++++++++++
 tb/tb_switch_launcher.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/switch_launcher.sv
// rtl/switch_launcher.sv - switch-driven launcher: sync/debounce, range check, start/busy handshake, timeout, latched result
module switch_launcher #(
    parameter int IN_W     = 16,
    parameter int ARG_W    = 5,
    parameter int ARG_MAX  = 24,
    parameter int OUT_W    = 16,
    parameter int DEBOUNCE = 4,
    parameter int TIMEOUT  = 0
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic [IN_W-1:0]  in,
    input  logic             rerun,
    output logic             k_start,
    output logic [ARG_W-1:0] k_arg,
    input  logic             k_busy,
    input  logic [OUT_W-1:0] k_result,
    output logic [OUT_W-1:0] out,
    output logic             done,
    output logic             err_range,
    output logic             err_timeout
);

    localparam int CNT_W  = $clog2(DEBOUNCE + 1);
    localparam int TCNT_W = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = CNT_W'(DEBOUNCE);
    localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);
    localparam logic [31:0]       ARG_MAX_U = 32'(ARG_MAX);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LAUNCH,
        S_RUN
    } state_t;

    state_t            state_q, state_d;
    logic [ARG_W-1:0]  s1_q, s1_d;
    logic [ARG_W-1:0]  s2_q, s2_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [TCNT_W-1:0] tcnt_q, tcnt_d;
    logic [ARG_W-1:0]  last_arg_q, last_arg_d;
    logic              last_vld_q, last_vld_d;
    logic [ARG_W-1:0]  k_arg_q, k_arg_d;
    logic              k_start_q, k_start_d;
    logic [OUT_W-1:0]  out_q, out_d;
    logic              done_q, done_d;
    logic              err_range_q, err_range_d;
    logic              err_timeout_q, err_timeout_d;

    logic        stable;
    logic        in_range;
    logic        want_launch;
    logic [31:0] s2_ext;

    // Upper switch bits are not part of the argument.
    generate
        if (IN_W > ARG_W) begin : g_unused
            logic unused_in_hi;
            assign unused_in_hi = ^in[IN_W-1:ARG_W];
        end
    endgenerate

    assign s2_ext      = 32'(s2_q);
    assign stable      = (cnt_q == CNT_MAX);
    assign in_range    = (s2_ext <= ARG_MAX_U);
    assign want_launch = stable && !k_busy && (!last_vld_q || (s2_q != last_arg_q) || rerun);

    always_comb begin
        state_d       = state_q;
        s1_d          = in[ARG_W-1:0];
        s2_d          = s1_q;
        cnt_d         = cnt_q;
        tcnt_d        = tcnt_q;
        last_arg_d    = last_arg_q;
        last_vld_d    = last_vld_q;
        k_arg_d       = k_arg_q;
        k_start_d     = 1'b0;
        out_d         = out_q;
        done_d        = 1'b0;
        err_range_d   = err_range_q;
        err_timeout_d = err_timeout_q;

        // Debounce counts cycles since the synchronised value last moved.
        if (s2_d != s2_q) begin
            cnt_d = '0;
        end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + CNT_W'(1);
        end

        if (stable && in_range) begin
            err_range_d = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                if (want_launch) begin
                    if (!in_range) begin
                        err_range_d = 1'b1;
                    end else begin
                        k_arg_d       = s2_q;
                        k_start_d     = 1'b1;
                        last_arg_d    = s2_q;
                        last_vld_d    = 1'b1;
                        err_range_d   = 1'b0;
                        err_timeout_d = 1'b0;
                        tcnt_d        = '0;
                        state_d       = S_LAUNCH;
                    end
                end
            end
            S_LAUNCH: begin
                state_d = S_RUN;
            end
            S_RUN: begin
                if (!k_busy) begin
                    out_d   = k_result;
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end else if ((TIMEOUT != 0) && (tcnt_q == TCNT_LAST)) begin
                    // Abandon the run; IDLE holds off until the kernel drops busy.
                    err_timeout_d = 1'b1;
                    state_d       = S_IDLE;
                end else begin
                    tcnt_d = tcnt_q + TCNT_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q       <= S_IDLE;
            s1_q          <= '0;
            s2_q          <= '0;
            cnt_q         <= '0;
            tcnt_q        <= '0;
            last_arg_q    <= '0;
            last_vld_q    <= 1'b0;
            k_arg_q       <= '0;
            k_start_q     <= 1'b0;
            out_q         <= '0;
            done_q        <= 1'b0;
            err_range_q   <= 1'b0;
            err_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            s1_q          <= s1_d;
            s2_q          <= s2_d;
            cnt_q         <= cnt_d;
            tcnt_q        <= tcnt_d;
            last_arg_q    <= last_arg_d;
            last_vld_q    <= last_vld_d;
            k_arg_q       <= k_arg_d;
            k_start_q     <= k_start_d;
            out_q         <= out_d;
            done_q        <= done_d;
            err_range_q   <= err_range_d;
            err_timeout_q <= err_timeout_d;
        end
    end

    assign k_start     = k_start_q;
    assign k_arg       = k_arg_q;
    assign out         = out_q;
    assign done        = done_q;
    assign err_range   = err_range_q;
    assign err_timeout = err_timeout_q;

endmodule

// File: tb/tb_switch_launcher.sv
// tb/tb_switch_launcher.sv - self-checking bench for switch_launcher with a model kernel
module tb_switch_launcher;
    localparam int IN_W     = 16;
    localparam int ARG_W    = 5;
    localparam int ARG_MAX  = 24;
    localparam int OUT_W    = 16;
    localparam int DEBOUNCE = 4;
    localparam int TIMEOUT  = 8;

    logic             clk  = 1'b0;
    logic             nrst = 1'b1;
    logic [IN_W-1:0]  in_sw = '0;
    logic             rerun = 1'b0;
    logic             k_start;
    logic [ARG_W-1:0] k_arg;
    logic             k_busy = 1'b0;
    logic [OUT_W-1:0] k_result;
    logic [OUT_W-1:0] out_w;
    logic             done;
    logic             err_range;
    logic             err_timeout;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    switch_launcher #(
        .IN_W(IN_W), .ARG_W(ARG_W), .ARG_MAX(ARG_MAX), .OUT_W(OUT_W),
        .DEBOUNCE(DEBOUNCE), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .nrst(nrst), .in(in_sw), .rerun(rerun),
        .k_start(k_start), .k_arg(k_arg), .k_busy(k_busy), .k_result(k_result),
        .out(out_w), .done(done), .err_range(err_range), .err_timeout(err_timeout)
    );

    // Model kernel: busy for min(arg+1,6) cycles (or stall_len), result arg*3.
    int               stall_len = 0;
    int               krem = 0;
    logic [OUT_W-1:0] kres = '0;

    function automatic int kernel_len(input int a);
        return (a + 1 > 6) ? 6 : a + 1;
    endfunction

    always @(posedge clk) begin
        if (k_start) begin
            k_busy <= 1'b1;
            krem   <= ((stall_len != 0) ? stall_len : kernel_len(int'(k_arg))) - 1;
            kres   <= OUT_W'(int'(k_arg) * 3);
        end else if (krem > 0) begin
            krem <= krem - 1;
        end else begin
            k_busy <= 1'b0;
        end
    end
    assign k_result = k_busy ? OUT_W'(16'hDEAD) : kres;

    // Event monitor, sampled 1 time unit after each rising edge.
    int               cyc = 0, n_start = 0, n_done = 0, n_overlap = 0;
    int               start_cyc = 0, fall_cyc = 0, tmo_cyc = 0;
    logic [ARG_W-1:0] start_arg = '0;
    logic             prev_busy = 1'b0, prev_tmo = 1'b0;
    int               start_q[$];

    always @(posedge clk) begin
        #1;
        cyc++;
        if (k_start) begin
            n_start++;
            start_cyc = cyc;
            start_arg = k_arg;
            start_q.push_back(cyc);
        end
        if (done) n_done++;
        if (done && k_start) n_overlap++;
        if (prev_busy && !k_busy) fall_cyc = cyc;
        prev_busy = k_busy;
        if (err_timeout && !prev_tmo) tmo_cyc = cyc;
        prev_tmo = err_timeout;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_start(input int s0, input int lim);
        for (int i = 0; i < lim && n_start == s0; i++) @(negedge clk);
    endtask

    task automatic wait_done(input int d0, input int lim);
        for (int i = 0; i < lim && n_done == d0; i++) @(negedge clk);
    endtask

    task automatic test_reset;
        #2 nrst = 1'b0;
        in_sw = IN_W'(5);
        tick(3);
        total++;
        if ({k_start, k_arg, out_w, done, err_range, err_timeout} !== '0) begin
            bad++;
            $display("FAIL reset_outputs got=%0h exp=0", {k_start, k_arg, out_w, done, err_range, err_timeout});
        end
        total++;
        if (n_start !== 0) begin bad++; $display("FAIL reset_no_start got=%0d exp=0", n_start); end
    endtask

    task automatic test_basic;
        int c0, s0, d0;
        c0 = cyc; s0 = n_start; d0 = n_done;
        nrst = 1'b1;
        wait_start(s0, 40);
        total++;
        if (n_start !== s0 + 1) begin bad++; $display("FAIL basic_start got=%0d exp=%0d", n_start, s0 + 1); end
        total++;
        if (start_cyc - c0 !== DEBOUNCE + 3) begin bad++; $display("FAIL basic_latency got=%0d exp=%0d", start_cyc - c0, DEBOUNCE + 3); end
        total++;
        if (start_arg !== ARG_W'(5)) begin bad++; $display("FAIL basic_arg got=%0d exp=5", start_arg); end
        wait_done(d0, 40);
        total++;
        if (out_w !== OUT_W'(15)) begin bad++; $display("FAIL basic_out got=%0d exp=15", out_w); end
        tick(40);
        total++;
        if (n_start !== s0 + 1) begin bad++; $display("FAIL basic_hold_starts got=%0d exp=%0d", n_start, s0 + 1); end
        total++;
        if (n_done !== d0 + 1) begin bad++; $display("FAIL basic_done_count got=%0d exp=%0d", n_done, d0 + 1); end
    endtask

    task automatic test_bounce;
        int s0;
        s0 = n_start;
        for (int i = 0; i < 10; i++) begin
            in_sw = (i % 2 == 0) ? IN_W'(9) : IN_W'(8);
            tick(2);
        end
        total++;
        if (n_start !== s0) begin bad++; $display("FAIL bounce_quiet got=%0d exp=%0d", n_start, s0); end
        in_sw = IN_W'(9);
        tick(30);
        total++;
        if (n_start !== s0 + 1) begin bad++; $display("FAIL bounce_one_start got=%0d exp=%0d", n_start, s0 + 1); end
        total++;
        if (start_arg !== ARG_W'(9)) begin bad++; $display("FAIL bounce_arg got=%0d exp=9", start_arg); end
        total++;
        if (out_w !== OUT_W'(27)) begin bad++; $display("FAIL bounce_out got=%0d exp=27", out_w); end
    endtask

    task automatic test_range;
        int s0;
        s0 = n_start;
        in_sw = IN_W'(30);
        tick(20);
        total++;
        if (err_range !== 1'b1) begin bad++; $display("FAIL range_flag got=%0d exp=1", err_range); end
        total++;
        if (n_start !== s0) begin bad++; $display("FAIL range_no_start got=%0d exp=%0d", n_start, s0); end
        total++;
        if (out_w !== OUT_W'(27)) begin bad++; $display("FAIL range_out_kept got=%0d exp=27", out_w); end
        in_sw = IN_W'(3);
        tick(30);
        total++;
        if (err_range !== 1'b0) begin bad++; $display("FAIL range_clear got=%0d exp=0", err_range); end
        total++;
        if (n_start !== s0 + 1 || start_arg !== ARG_W'(3)) begin
            bad++; $display("FAIL range_recover starts=%0d arg=%0d exp=%0d/3", n_start, start_arg, s0 + 1);
        end
        total++;
        if (out_w !== OUT_W'(9)) begin bad++; $display("FAIL range_out got=%0d exp=9", out_w); end
    endtask

    task automatic test_rerun;
        int d0;
        in_sw = IN_W'(2);
        tick(30);
        start_q.delete();
        d0 = n_done;
        rerun = 1'b1;
        tick(40);
        rerun = 1'b0;
        tick(20);
        total++;
        if (start_q.size() < 4) begin bad++; $display("FAIL rerun_count got=%0d exp>=4", start_q.size()); end
        for (int i = 1; i < start_q.size(); i++) begin
            total++;
            if (start_q[i] - start_q[i-1] !== 6) begin
                bad++; $display("FAIL rerun_gap idx=%0d got=%0d exp=6", i, start_q[i] - start_q[i-1]);
            end
        end
        total++;
        if (n_done - d0 !== start_q.size()) begin bad++; $display("FAIL rerun_dones got=%0d exp=%0d", n_done - d0, start_q.size()); end
        total++;
        if (out_w !== OUT_W'(6)) begin bad++; $display("FAIL rerun_out got=%0d exp=6", out_w); end
    endtask

    task automatic test_timeout;
        int s0, d0, f0;
        stall_len = 20;
        s0 = n_start;
        in_sw = IN_W'(4);
        wait_start(s0, 40);
        d0 = n_done;
        for (int i = 0; i < 30 && !err_timeout; i++) @(negedge clk);
        total++;
        if (err_timeout !== 1'b1) begin bad++; $display("FAIL timeout_flag got=%0d exp=1", err_timeout); end
        total++;
        if (tmo_cyc - start_cyc !== TIMEOUT + 1) begin bad++; $display("FAIL timeout_latency got=%0d exp=%0d", tmo_cyc - start_cyc, TIMEOUT + 1); end
        total++;
        if (out_w !== OUT_W'(6) || n_done !== d0) begin bad++; $display("FAIL timeout_out got=%0d dones=%0d exp=6/%0d", out_w, n_done, d0); end
        stall_len = 0;
        f0 = fall_cyc;
        s0 = n_start;
        rerun = 1'b1;
        wait_start(s0, 40);
        rerun = 1'b0;
        total++;
        if (n_start !== s0 + 1) begin bad++; $display("FAIL timeout_relaunch got=%0d exp=%0d", n_start, s0 + 1); end
        total++;
        if (fall_cyc == f0 || start_cyc <= fall_cyc) begin
            bad++; $display("FAIL timeout_wait_busy start=%0d fall=%0d exp start after fall", start_cyc, fall_cyc);
        end
        d0 = n_done;
        wait_done(d0, 40);
        tick(1);
        total++;
        if (err_timeout !== 1'b0 || out_w !== OUT_W'(12)) begin
            bad++; $display("FAIL timeout_recover flag=%0d out=%0d exp=0/12", err_timeout, out_w);
        end
    endtask

    task automatic test_reset_mid_run;
        int s0, d0, f0;
        stall_len = 20;
        s0 = n_start;
        in_sw = IN_W'(7);
        wait_start(s0, 40);
        tick(3);
        nrst = 1'b0;
        #1;
        total++;
        if ({k_start, k_arg, out_w, done, err_range, err_timeout} !== '0) begin
            bad++; $display("FAIL midrun_reset got=%0h exp=0", {k_start, k_arg, out_w, done, err_range, err_timeout});
        end
        stall_len = 0;
        tick(2);
        f0 = fall_cyc;
        s0 = n_start;
        nrst = 1'b1;
        wait_start(s0, 60);
        total++;
        if (n_start !== s0 + 1 || start_arg !== ARG_W'(7)) begin
            bad++; $display("FAIL midrun_relaunch starts=%0d arg=%0d exp=%0d/7", n_start, start_arg, s0 + 1);
        end
        total++;
        if (fall_cyc == f0 || start_cyc <= fall_cyc) begin
            bad++; $display("FAIL midrun_wait_busy start=%0d fall=%0d exp start after fall", start_cyc, fall_cyc);
        end
        d0 = n_done;
        wait_done(d0, 40);
        total++;
        if (out_w !== OUT_W'(21)) begin bad++; $display("FAIL midrun_out got=%0d exp=21", out_w); end
    endtask

    // Window-level model: each held value yields at most one launch, decided by range and last launched arg.
    task automatic test_random;
        int               mlast, v, s0, d0, c0, exp_starts;
        logic             exp_err;
        logic [OUT_W-1:0] mout;
        logic [31:0]      r;
        mlast = 7;
        mout  = OUT_W'(21);
        for (int i = 0; i < 14; i++) begin
            v = (i % 5 == 4) ? mlast : int'($urandom_range(0, 31));
            r = $urandom;
            s0 = n_start; d0 = n_done; c0 = cyc;
            in_sw = {r[IN_W-1:ARG_W], v[ARG_W-1:0]};
            tick(30);
            if (v > ARG_MAX) begin
                exp_starts = 0; exp_err = 1'b1;
            end else if (v != mlast) begin
                exp_starts = 1; exp_err = 1'b0; mlast = v; mout = OUT_W'(3 * v);
            end else begin
                exp_starts = 0; exp_err = 1'b0;
            end
            total++;
            if (n_start - s0 !== exp_starts) begin bad++; $display("FAIL rand_starts v=%0d got=%0d exp=%0d", v, n_start - s0, exp_starts); end
            total++;
            if (n_done - d0 !== exp_starts) begin bad++; $display("FAIL rand_dones v=%0d got=%0d exp=%0d", v, n_done - d0, exp_starts); end
            total++;
            if (err_range !== exp_err) begin bad++; $display("FAIL rand_err_range v=%0d got=%0d exp=%0d", v, err_range, exp_err); end
            total++;
            if (out_w !== mout) begin bad++; $display("FAIL rand_out v=%0d got=%0d exp=%0d", v, out_w, mout); end
            if (exp_starts == 1) begin
                total++;
                if (start_arg !== v[ARG_W-1:0] || start_cyc - c0 !== DEBOUNCE + 3) begin
                    bad++; $display("FAIL rand_launch v=%0d arg=%0d lat=%0d exp lat=%0d", v, start_arg, start_cyc - c0, DEBOUNCE + 3);
                end
            end
        end
    endtask

    task automatic test_no_overlap;
        total++;
        if (n_overlap !== 0) begin bad++; $display("FAIL done_start_overlap got=%0d exp=0", n_overlap); end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_bounce;
        test_range;
        test_rerun;
        test_timeout;
        test_reset_mid_run;
        test_random;
        test_no_overlap;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule
